// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 single multiplier (operand capture, multiply, normalize/round, pack) with valid/stall and tag; ports clk, rst, valid_in, x1, x2, tag_in, stall -> valid_out, y, tag_out
module fmul_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             stall,
  output logic             valid_out,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] tag_out
);
  logic             v0, v1, v2;
  logic [31:0]      a0, b0;
  logic [TAG_W-1:0] t0, t1, t2;
  logic             sg1, sp1, sg2, sp2, z2;
  logic [47:0]      p1;
  logic [9:0]       es1, e2;
  logic [23:0]      s2;
  logic [23:0]      ma, mb;
  logic [7:0]       ea, eb;
  logic [47:0]      p_n;
  logic [9:0]       es_n;
  logic             sp_n;
  logic [5:0]       l;
  logic [24:0]      sr, sum;
  logic [23:0]      s_n;
  logic [9:0]       e_n;
  logic [9:0]       sh;
  logic [22:0]      den;
  logic             ovf, udf;
  logic [31:0]      y_n;
  always_comb begin
    ma = {|a0[30:23], a0[22:0]};
    mb = {|b0[30:23], b0[22:0]};
    ea = a0[30:23] == 8'd0 ? 8'd1 : a0[30:23];
    eb = b0[30:23] == 8'd0 ? 8'd1 : b0[30:23];
    p_n = 48'(ma) * 48'(mb);
    es_n = 10'(ea) + 10'(eb) - 10'd127;
    sp_n = &a0[30:23] | &b0[30:23];
  end
  always_comb begin
    l = 6'd0;
    for (int i = 0; i < 48; i++) if (p1[i]) l = 6'(i);
    // sr holds the 24 significand bits (leading one at bit 24) followed by the round bit
    sr = 25'((p1 << (6'd47 - l)) >> 23);
    sum = 25'(sr[24:1]) + 25'(sr[0]);
    s_n = sum[24] ? 24'h800000 : sum[23:0];
    e_n = es1 + 10'(l) - 10'd46 + 10'(sum[24]);
  end
  always_comb begin
    sh = 10'd1 - e2;
    den = sh > 10'd23 ? 23'd0 : 23'(s2 >> sh);
    ovf = !e2[9] && e2 >= 10'd255;
    udf = e2[9] || e2 == 10'd0;
    y_n = sp2 ? {sg2, 8'hff, 23'd0} :
          z2  ? {sg2, 31'd0} :
          ovf ? {sg2, 8'hff, 23'd0} :
          udf ? {sg2, 8'h00, den} :
                {sg2, e2[7:0], s2[22:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0; a0 <= '0; b0 <= '0; t0 <= '0;
      v1 <= 1'b0; sg1 <= 1'b0; sp1 <= 1'b0; p1 <= '0; es1 <= '0; t1 <= '0;
      v2 <= 1'b0; sg2 <= 1'b0; sp2 <= 1'b0; z2 <= 1'b0; e2 <= '0; s2 <= '0; t2 <= '0;
      valid_out <= 1'b0; y <= '0; tag_out <= '0;
    end else if (!stall) begin
      v0 <= valid_in; a0 <= x1; b0 <= x2; t0 <= tag_in;
      v1 <= v0; sg1 <= a0[31] ^ b0[31]; sp1 <= sp_n; p1 <= p_n; es1 <= es_n; t1 <= t0;
      v2 <= v1; sg2 <= sg1; sp2 <= sp1; z2 <= p1 == 48'd0; e2 <= e_n; s2 <= s_n; t2 <= t1;
      valid_out <= v2; y <= y_n; tag_out <= t2;
    end
  end
endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Pipelined IEEE-754 single-precision multiplier; the inverse-direction companion of the combinational divider in the FPU.
- Accepts one operand pair per cycle and returns the product after 3 cycles.
- Uses a valid/stall handshake so the core's FPU issue logic can hold it during back-pressure.
- Carries a destination tag alongside each operation for writeback.

Parameters:
- TAG_W, 5: width of the opaque tag (destination register id) carried with each operation.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  x1/x2/tag_in hold a new operation this cycle
- x1  in  32  multiplicand (IEEE single)
- x2  in  32  multiplier (IEEE single)
- tag_in  in  TAG_W  tag for this operation
- stall  in  1  freeze the whole pipeline this cycle
- valid_out  out  1  y/tag_out hold a completed result
- y  out  32  product
- tag_out  out  TAG_W  tag of the result on y

Behaviour:
- Reset: one clock, synchronous, active-high. On any rising edge with rst=1, every pipeline register clears to 0. This gives valid_out=0, y=0, tag_out=0.
- Reset mid-operation: all in-flight operations are discarded; none reappear after rst falls.
- Latency: an operation accepted at edge N (valid_in=1, stall=0) appears on valid_out/y/tag_out after edge N+3, assuming no stall cycles. Throughput is 1 per cycle.
- Stall: when stall=1 (and rst=0), all stage registers hold, including valid_out/y/tag_out. valid_in and operands are ignored that cycle; the issuer must re-present them. Reset takes priority over stall.
- Bubbles: valid_in=0 with stall=0 inserts a bubble. Bubble data is don't-care, but valid is 0.
- Stage 1 (unpack and multiply):
  - sign = s1^s2.
  - Significand = {hidden,frac}; hidden = 0 when exp==0, else 1.
  - Effective exponent = max(exp,1).
  - Register the 48-bit product P, esum = ee1+ee2-127 (signed, 10 bits), and a special flag: either exp==255.
- Stage 2 (normalize and round):
  - L = index of the leading one of P.
  - E = esum + (L-46).
  - Significand S = P[L:L-23]; bits below L-23 are zero-filled when L<23.
  - Round bit R = P[L-24], or 0 when L<24. Round half-up on magnitude: S += R.
  - If the addition carries out to 2^24: S = 2^23 and E += 1.
  - If P == 0: the result is a zero flag.
- Stage 3 (pack):
  - special → {sign, 8'hFF, 23'b0}. This applies to inf and NaN inputs, and also to 0×inf; there is no NaN generation.
  - zero → {sign, 31'b0}.
  - E >= 255 → {sign, 8'hFF, 23'b0}.
  - E <= 0 → denormal {sign, 8'h00, (S >> (1-E))[22:0]}, truncating after the shift; a shift ≥ 24 gives 0 mantissa. No second rounding.
  - Otherwise → {sign, E[7:0], S[22:0]}.
- Denormal inputs are fully supported: the leading-one search covers all 48 bits of P.
- Signed zero is preserved: sign is always s1^s2.
- The tag travels with its valid bit unchanged through all 3 stages.

Test Plan:
1. Reset then basic product: rst 1 cycle; x1=0x40000000 (2.0), x2=0x40400000 (3.0), valid_in=1 → 3 cycles later valid_out=1, y=0x40C00000, tag_out=tag_in. Sign case: x1=0xC0000000 → y=0xC0C00000.
2. Rounding:
   - 0x3F800001×0x3F800001 → 0x3F800002.
   - Tie case 0x3F800001×0x3FC00000 → 0x3FC00002 (half-up).
   - 0x3FC00000×0x3FC00000 → 0x40100000.
3. Range limits:
   - Overflow 0x7F000000×0x40000000 → 0x7F800000.
   - Underflow to denormal 0x00800000×0x3F000000 → 0x00400000.
   - Full underflow 0x00800000×0x00800000 → 0x00000000.
   - Zero 0x80000000×0x40000000 → 0x80000000.
4. Special operands: 0x7F800000×0x3F800000 → 0x7F800000. Denormal input 0x00400000×0x40800000 (2^-127×4) → 0x01000000.
5. Streaming with stall and bubbles: issue 5 back-to-back ops with tags 1..5; assert stall for 2 cycles after the 2nd issue and drop valid_in for 1 cycle. Required:
   - results emerge in order with correct tags;
   - y/valid_out are held constant during the stall;
   - no op is lost or duplicated;
   - exactly one bubble appears.
6. Reset mid-flight: 3 ops in flight, rst=1 for 1 cycle → valid_out=0 and y=0 on the following cycles until new ops arrive; new op issued right after reset returns the correct result at latency 3.
